kick_commander: RTL and testbench

KICK_COMMANDER -- requirements
Module: kick_commander

---
 rtl/kick_pkg.sv | 48 ++++
 rtl/ir_debounce.sv | 42 ++++
 rtl/kick_commander.sv | 146 ++++++++++++++
 tb/tb_kick_commander.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kick_pkg.sv
// Shared types and helpers for the kick commander: FSM states, outcome codes
// and the strength-to-kick_time mapping expected by the kicker board.
package kick_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_FIRE      = 3'd2,
        ST_WAIT_TRIG = 3'd3,
        ST_COOLDOWN  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STS_KICKED       = 2'b00,
        STS_NO_BALL      = 2'b01,
        STS_TRIG_TIMEOUT = 2'b10,
        STS_INVALID      = 2'b11
    } status_t;

    localparam int unsigned STRENGTH_MIN = 1;
    localparam int unsigned STRENGTH_MAX = 11;
    localparam int unsigned CNT_W        = 21;

    function automatic logic strength_legal(input logic [3:0] s);
        return (s >= 4'(STRENGTH_MIN)) && (s <= 4'(STRENGTH_MAX));
    endfunction

    // The kicker decodes these patterns directly; 4 is deliberately five ones.
    function automatic logic [6:0] encode_strength(input logic [3:0] s);
        logic [6:0] code;
        case (s)
            4'd1:    code = 7'b0000001;
            4'd2:    code = 7'b0000011;
            4'd3:    code = 7'b0000111;
            4'd4:    code = 7'b0011111;
            4'd5:    code = 7'b1000000;
            4'd6:    code = 7'b1100000;
            4'd7:    code = 7'b1110000;
            4'd8:    code = 7'b1111000;
            4'd9:    code = 7'b1111100;
            4'd10:   code = 7'b1111110;
            4'd11:   code = 7'b1111111;
            default: code = 7'b0000000;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ir_debounce.sv
// Ball-present sensor conditioning: two-flop synchronizer followed by a
// debouncer that flips only after IR_STABLE consecutive differing samples.
module ir_debounce #(
    parameter int unsigned IR_STABLE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ir_i,
    output logic ir_deb_o
);

    localparam int unsigned CW = (IR_STABLE > 1) ? $clog2(IR_STABLE) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ir_i;
            sync2_q <= sync1_q;
            // cnt_q counts differing samples already seen; the next one commits.
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(IR_STABLE - 1)) begin
                deb_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign ir_deb_o = deb_q;

endmodule

// File: rtl/kick_commander.sv
// Kick sequencer: accepts a host kick command, waits for the ball, fires the
// kicker, waits for its discharge, cools down and reports one outcome.
module kick_commander
    import kick_pkg::*;
#(
    parameter int unsigned IR_TIMEOUT   = 1000000,
    parameter int unsigned TRIG_TIMEOUT = 2000000,
    parameter int unsigned COOLDOWN     = 500000,
    parameter int unsigned IR_STABLE    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_strength,
    input  logic       cmd_abort,
    input  logic       ir,
    input  logic       trigger_in,
    output logic       cmd_ready,
    output logic       charge_flag,
    output logic [6:0] kick_time,
    output logic       done,
    output logic [1:0] status
);

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [3:0]       strength_q, strength_d;
    status_t          status_q,   status_d;
    logic             done_q,     done_d;
    logic             charge_q,   charge_d;
    logic [6:0]       kick_q,     kick_d;
    logic             trig_prev_q;
    logic             ir_deb;
    logic [CNT_W-1:0] cnt_inc;

    ir_debounce #(
        .IR_STABLE (IR_STABLE)
    ) u_ir_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .ir_i     (ir),
        .ir_deb_o (ir_deb)
    );

    // Saturating increment: a stuck counter is safer than a wrapped one.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        strength_d = strength_q;
        status_d   = status_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    strength_d = cmd_strength;
                    cnt_d      = '0;
                    if (strength_legal(cmd_strength)) begin
                        state_d = ST_ARM;
                    end else begin
                        done_d   = 1'b1;
                        status_d = STS_INVALID;
                    end
                end
            end
            ST_ARM: begin
                if (cmd_abort) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    status_d = STS_INVALID;
                end else if (ir_deb) begin
                    state_d = ST_FIRE;
                end else if (cnt_q >= CNT_W'(IR_TIMEOUT - 1)) begin
                    state_d  = ST_COOLDOWN;
                    status_d = STS_NO_BALL;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_FIRE: begin
                state_d = ST_WAIT_TRIG;
                cnt_d   = '0;
            end
            ST_WAIT_TRIG: begin
                if (trigger_in && !trig_prev_q) begin
                    state_d  = ST_COOLDOWN;
                    status_d = STS_KICKED;
                    cnt_d    = '0;
                end else if (cnt_q >= CNT_W'(TRIG_TIMEOUT - 1)) begin
                    state_d  = ST_COOLDOWN;
                    status_d = STS_TRIG_TIMEOUT;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_COOLDOWN: begin
                if (cnt_q >= CNT_W'(COOLDOWN - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        charge_d = (state_d == ST_FIRE) || (state_d == ST_WAIT_TRIG);
        kick_d   = charge_d ? encode_strength(strength_d) : 7'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            strength_q  <= '0;
            status_q    <= STS_KICKED;
            done_q      <= 1'b0;
            charge_q    <= 1'b0;
            kick_q      <= '0;
            trig_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            strength_q  <= strength_d;
            status_q    <= status_d;
            done_q      <= done_d;
            charge_q    <= charge_d;
            kick_q      <= kick_d;
            trig_prev_q <= trigger_in;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign charge_flag = charge_q;
    assign kick_time   = kick_q;
    assign done        = done_q;
    assign status      = status_q;

endmodule

// File: tb/tb_kick_commander.sv
// Randomized scoreboard bench for kick_commander: stimulus pushes predicted
// outcomes, a negedge monitor checks every done pulse and kicker output.
module tb_kick_commander;

    localparam int IR_TO   = 20;
    localparam int TRIG_TO = 30;
    localparam int CD      = 5;
    localparam int IRS     = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_strength = 4'd0;
    logic       cmd_abort = 1'b0;
    logic       ir = 1'b0;
    logic       trigger_in = 1'b0;
    logic       cmd_ready;
    logic       charge_flag;
    logic [6:0] kick_time;
    logic       done;
    logic [1:0] status;

    kick_commander #(
        .IR_TIMEOUT   (IR_TO),
        .TRIG_TIMEOUT (TRIG_TO),
        .COOLDOWN     (CD),
        .IR_STABLE    (IRS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_strength (cmd_strength),
        .cmd_abort    (cmd_abort),
        .ir           (ir),
        .trigger_in   (trigger_in),
        .cmd_ready    (cmd_ready),
        .charge_flag  (charge_flag),
        .kick_time    (kick_time),
        .done         (done),
        .status       (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] status;
        logic [6:0] kick;
        int         charge_len;
        int         done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   charge_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Strength 1..3 light the low bits, 4 lights five, 5..11 fill from the top.
    function automatic logic [6:0] model_kick(input int s);
        int v;
        if (s < 1 || s > 11) v = 0;
        else if (s <= 3)     v = (1 << s) - 1;
        else if (s == 4)     v = 31;
        else                 v = (127 << (11 - s)) & 127;
        return 7'(v);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n !== 1'b1) begin
            charge_cnt = 0;
        end else begin
            if (charge_flag) begin
                charge_cnt++;
                if (exp_q.size() == 0) check("charge_without_cmd", 32'(charge_flag), 32'd0);
                else                   check("kick_time", 32'(kick_time), 32'(exp_q[0].kick));
            end else begin
                check("kick_time_idle", 32'(kick_time), 32'd0);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("status", 32'(status), 32'(e.status));
                    check("charge_cycles", 32'(charge_cnt), 32'(e.charge_len));
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                end
                charge_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [3:0] s, output int a);
        @(posedge clk); #1;
        cmd_valid    = 1'b1;
        cmd_strength = s;
        check("ready_in_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        a = cyc;
    endtask

    task automatic wait_charge(output bit got);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk); #1;
            got = charge_flag;
        end
        if (!got) check("charge_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int n = 0; n < 80 && !got; n++) begin
            @(negedge clk);
            got = done;
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    // sc: 0 ball present + kick (trigger d cycles after charge, >30 = never),
    //     1 no ball, 2 short ir glitch then abort in the k-th ARM cycle.
    task automatic run_txn(input logic [3:0] s, input int sc, input int d, input int k);
        exp_t e;
        int   a;
        bit   legal, got;
        legal = (s >= 1 && s <= 11);
        ir = (sc == 0);
        repeat (10) @(posedge clk);
        #1;
        issue(s, a);
        e.kick       = model_kick(int'(s));
        e.charge_len = 0;
        if (!legal) begin
            e.status = 2'b11; e.done_cyc = a;
        end else if (sc == 0) begin
            if (d <= TRIG_TO) begin
                e.status = 2'b00; e.charge_len = d + 1; e.done_cyc = a + 2 + d + CD;
            end else begin
                e.status = 2'b10; e.charge_len = TRIG_TO + 1; e.done_cyc = a + 2 + TRIG_TO + CD;
            end
        end else if (sc == 1) begin
            e.status = 2'b01; e.done_cyc = a + IR_TO + CD;
        end else begin
            e.status = 2'b11; e.done_cyc = a + k;
        end
        exp_q.push_back(e);
        $display("txn strength=%0d scenario=%0d d=%0d k=%0d -> status=%0d", s, sc, d, k, e.status);

        if (!legal) begin
            check("ready_after_invalid", 32'(cmd_ready), 32'd1);
        end else if (sc == 0) begin
            wait_charge(got);
            if (got) begin
                for (int i = 1; i <= ((d <= TRIG_TO) ? d : 3); i++) begin
                    @(posedge clk); #1;
                    cmd_valid  = (i == 2);
                    cmd_abort  = (i == 2);
                    trigger_in = (d <= TRIG_TO) && (i == d);
                    if (i == 2) begin
                        cmd_strength = 4'($urandom_range(0, 15));
                        check("ready_busy", 32'(cmd_ready), 32'd0);
                    end
                end
                @(posedge clk); #1;
                cmd_valid = 1'b0; cmd_abort = 1'b0; trigger_in = 1'b0;
            end
        end else if (sc == 2) begin
            for (int i = 1; i < k; i++) begin
                @(posedge clk); #1;
                ir        = (i <= 3);
                cmd_abort = (i == k - 1);
            end
            @(posedge clk); #1;
            cmd_abort = 1'b0; ir = 1'b0;
        end
        wait_done();
    endtask

    initial begin : stim
        int  a;
        bit  got;
        exp_t e;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_ready",  32'(cmd_ready),   32'd1);
        check("rst_charge", 32'(charge_flag), 32'd0);
        check("rst_kick",   32'(kick_time),   32'd0);
        check("rst_done",   32'(done),        32'd0);
        check("rst_status", 32'(status),      32'd0);

        run_txn(4'd3,  0, 10, 0);
        run_txn(4'd0,  0, 0,  0);
        run_txn(4'd12, 1, 0,  0);
        run_txn(4'd11, 1, 0,  0);
        run_txn(4'd5,  0, 99, 0);
        run_txn(4'd8,  2, 0,  10);
        run_txn(4'd4,  0, 30, 0);
        run_txn(4'd9,  0, 1,  0);

        for (int t = 0; t < 30; t++) begin
            logic [3:0] s;
            if ($urandom_range(0, 4) == 0) s = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(12, 15));
            else                           s = 4'($urandom_range(1, 11));
            run_txn(s, int'($urandom_range(0, 2)), int'($urandom_range(1, 36)), int'($urandom_range(8, 15)));
        end

        // Reset while the kicker is charging: outputs drop at once, no done.
        ir = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        issue(4'd7, a);
        e.kick = model_kick(7); e.status = 2'b00; e.charge_len = 0; e.done_cyc = 0;
        exp_q.push_back(e);
        wait_charge(got);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("txn reset during WAIT_TRIG");
        check("async_rst_charge", 32'(charge_flag), 32'd0);
        check("async_rst_kick",   32'(kick_time),   32'd0);
        check("async_rst_done",   32'(done),        32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_ready",  32'(cmd_ready), 32'd1);
        check("post_rst_status", 32'(status),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
